// File: rtl/msg_block_feeder.sv
// msg_block_feeder: packs a 64-byte host stream into a 16-word buffer, starts
// the hash engine, serves its word reads, captures the digest and returns it
// to the host over a valid/ready handshake.
module msg_block_feeder #(
  parameter int DIGEST_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        hash_start,
  input  logic [3:0]  hash_addr,
  input  logic        hash_rd,
  output logic [31:0] hash_word,
  input  logic [31:0] hash_result,
  input  logic        hash_valid,
  output logic [31:0] digest_out,
  output logic        digest_valid,
  input  logic        digest_ready
);

  localparam int IW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGEST_WORDS - 1);

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    CAPTURE,
    EMIT
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    bc_q, bc_d;
  logic [IW-1:0] dc_q, dc_d;
  logic [IW-1:0] ec_q, ec_d;
  logic [31:0]   buf_q [16];
  logic [31:0]   dig_q [DIGEST_WORDS];

  logic          byteFire;
  logic          capFire;
  logic [IW-1:0] capIdx;
  logic          unusedRd;

  // The read strobe carries no information: reads are unconditional.
  assign unusedRd = hash_rd;

  // State and counter registers; reset discards any partial block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      bc_q    <= '0;
      dc_q    <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      dc_q    <= dc_d;
      ec_q    <= ec_d;
    end
  end

  // Next-state logic plus the byte-store and digest-store enables.
  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    dc_d     = dc_q;
    ec_d     = ec_q;
    byteFire = 1'b0;
    capFire  = 1'b0;
    capIdx   = dc_q;
    case (state_q)
      LOAD: begin
        if (byte_valid) begin
          byteFire = 1'b1;
          bc_d     = bc_q + 6'd1;
          if (bc_q == 6'd63) state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (hash_valid) begin
          capFire = 1'b1;
          capIdx  = '0;
          if (DIGEST_WORDS == 1) begin
            state_d = EMIT;
          end else begin
            state_d = CAPTURE;
            dc_d    = IW'(1);
          end
        end
      end
      CAPTURE: begin
        if (hash_valid) begin
          capFire = 1'b1;
          dc_d    = dc_q + IW'(1);
          if (dc_q == LAST_IDX) begin
            state_d = EMIT;
            dc_d    = '0;
          end
        end
      end
      EMIT: begin
        if (digest_ready) begin
          if (ec_q == LAST_IDX) begin
            state_d = LOAD;
            ec_d    = '0;
            dc_d    = '0;
          end else begin
            ec_d = ec_q + IW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Message buffer: little-endian byte lanes, written only while loading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else if (byteFire) begin
      buf_q[bc_q[5:2]][{bc_q[1:0], 3'b000} +: 8] <= byte_in;
    end
  end

  // Digest registers, filled in arrival order by the engine's valid words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= '0;
    end else if (capFire) begin
      dig_q[capIdx] <= hash_result;
    end
  end

  assign byte_ready   = (state_q == LOAD);
  assign hash_start   = (state_q == START);
  assign digest_valid = (state_q == EMIT);
  assign digest_out   = (state_q == EMIT) ? dig_q[ec_q] : 32'h0;
  assign hash_word    = buf_q[hash_addr];

endmodule

// File: tb/tb_msg_block_feeder.sv
// Randomized self-checking bench for msg_block_feeder with a byte-level
// reference model of the message block and digest sequence.
module tb_msg_block_feeder;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        hash_start;
  logic [3:0]  hash_addr;
  logic        hash_rd;
  logic [31:0] hash_word;
  logic [31:0] hash_result;
  logic        hash_valid;
  logic [31:0] digest_out;
  logic        digest_valid;
  logic        digest_ready;

  int checks = 0;
  int failures = 0;

  logic [7:0]  refBytes [64];
  logic [31:0] refDigest [4];

  msg_block_feeder #(.DIGEST_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .hash_start   (hash_start),
    .hash_addr    (hash_addr),
    .hash_rd      (hash_rd),
    .hash_word    (hash_word),
    .hash_result  (hash_result),
    .hash_valid   (hash_valid),
    .digest_out   (digest_out),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refWord(input int w);
    return {refBytes[4*w+3], refBytes[4*w+2], refBytes[4*w+1], refBytes[4*w]};
  endfunction

  // Stream bytes: mode 0 back-to-back, 1 alternating, 2 random valid.
  // Byte values are the index for modes 0/1 and random for mode 2.
  task automatic applyStimulus(input int mode, input int count);
    int n = 0;
    int cycles = 0;
    while (n < count && cycles < 2000) begin
      case (mode)
        0: byte_valid = 1'b1;
        1: byte_valid = cycles[0] ? 1'b1 : 1'b0;
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_in      = (mode < 2) ? 8'(n) : 8'($urandom);
      hash_valid   = 1'($urandom_range(0, 1));
      hash_result  = $urandom;
      hash_addr    = 4'($urandom);
      hash_rd      = 1'($urandom_range(0, 1));
      digest_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("byte_ready_load", 32'(byte_ready), 32'd1);
      checkOutput("hash_start_load", 32'(hash_start), 32'd0);
      checkOutput("digest_valid_load", 32'(digest_valid), 32'd0);
      @(posedge clk);
      if (byte_valid) begin
        refBytes[n] = byte_in;
        n++;
      end
      #1;
      cycles++;
    end
    byte_valid = 1'b0;
    hash_valid = 1'b0;
    if (n < count) checkOutput("load_timeout", 32'(n), 32'(count));
    if (count == 64) begin
      @(negedge clk);
      checkOutput("hash_start_pulse", 32'(hash_start), 32'd1);
      checkOutput("byte_ready_start", 32'(byte_ready), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Walk every buffer address in WAIT while junk bytes are offered.
  task automatic checkBuffer();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      hash_valid = 1'b0;
      hash_rd    = 1'($urandom_range(0, 1));
      hash_addr  = 4'(a);
      #1;
      checkOutput($sformatf("hash_word[%0d]", a), hash_word, refWord(a));
      checkOutput("hash_start_wait", 32'(hash_start), 32'd0);
      checkOutput("byte_ready_wait", 32'(byte_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  // Feed digest words: mode 0 uses the fixed gapped pattern, else random.
  task automatic captureDigest(input int mode, input int limit);
    int k = 0;
    int cycles = 0;
    while (k < limit && cycles < 2000) begin
      if (mode == 0) begin
        hash_valid  = (cycles != 1 && cycles != 4);
        hash_result = 32'hAAAA0001 + 32'(k);
      end else begin
        hash_valid  = 1'($urandom_range(0, 1));
        hash_result = $urandom;
      end
      byte_valid   = 1'($urandom_range(0, 1));
      byte_in      = 8'($urandom);
      digest_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("byte_ready_capture", 32'(byte_ready), 32'd0);
      checkOutput("digest_valid_capture", 32'(digest_valid), 32'd0);
      @(posedge clk);
      if (hash_valid) begin
        refDigest[k] = hash_result;
        k++;
      end
      #1;
      cycles++;
    end
    hash_valid = 1'b0;
    byte_valid = 1'b0;
    if (k < limit) checkOutput("capture_timeout", 32'(k), 32'(limit));
  endtask

  // Drain the digest: mode 1 stalls 5 cycles per word, else random ready.
  task automatic emitDigest(input int mode);
    int e = 0;
    int stall = 0;
    int cycles = 0;
    while (e < 4 && cycles < 2000) begin
      digest_ready = (mode == 1) ? (stall == 5) : 1'($urandom_range(0, 1));
      hash_valid   = 1'($urandom_range(0, 1));
      hash_result  = $urandom;
      byte_valid   = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("digest_valid_emit", 32'(digest_valid), 32'd1);
      checkOutput($sformatf("digest_out[%0d]", e), digest_out, refDigest[e]);
      checkOutput("byte_ready_emit", 32'(byte_ready), 32'd0);
      @(posedge clk);
      if (digest_ready) begin
        e++;
        stall = 0;
      end else begin
        stall++;
      end
      #1;
      cycles++;
    end
    digest_ready = 1'b0;
    hash_valid   = 1'b0;
    byte_valid   = 1'b0;
    if (e < 4) checkOutput("emit_timeout", 32'(e), 32'd4);
    @(negedge clk);
    checkOutput("byte_ready_after_emit", 32'(byte_ready), 32'd1);
    checkOutput("digest_valid_after_emit", 32'(digest_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously and confirm every output is cleared.
  task automatic applyReset();
    rst = 1'b0;
    byte_valid = 1'b0;
    hash_valid = 1'b0;
    digest_ready = 1'b0;
    #1;
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd1);
    checkOutput("rst_hash_start", 32'(hash_start), 32'd0);
    checkOutput("rst_digest_valid", 32'(digest_valid), 32'd0);
    checkOutput("rst_digest_out", digest_out, 32'd0);
    for (int a = 0; a < 16; a++) begin
      hash_addr = 4'(a);
      #1;
      checkOutput($sformatf("rst_hash_word[%0d]", a), hash_word, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic fullBlock(input int loadMode, input int capMode, input int emitMode);
    applyStimulus(loadMode, 64);
    checkBuffer();
    captureDigest(capMode, 4);
    emitDigest(emitMode);
  endtask

  // Main sequence: directed test-plan cases, then randomized blocks.
  initial begin
    rst = 1'b0;
    byte_in = '0;
    byte_valid = 1'b0;
    hash_addr = '0;
    hash_rd = 1'b0;
    hash_result = '0;
    hash_valid = 1'b0;
    digest_ready = 1'b0;
    #2;
    applyReset();

    applyStimulus(0, 64);
    hash_addr = 4'd0;
    #1;
    checkOutput("packing_word0", hash_word, 32'h03020100);
    hash_addr = 4'd15;
    #1;
    checkOutput("packing_word15", hash_word, 32'h3F3E3D3C);
    checkBuffer();
    captureDigest(0, 4);
    checkOutput("directed_digest3", refDigest[3], 32'hAAAA0004);
    emitDigest(1);

    fullBlock(1, 1, 2);

    applyStimulus(2, 30);
    applyReset();
    fullBlock(0, 1, 2);

    applyStimulus(2, 64);
    checkBuffer();
    captureDigest(1, 2);
    applyReset();
    fullBlock(2, 1, 1);

    for (int r = 0; r < 3; r++) fullBlock(2, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
